graph_column_buffer: RTL and testbench

Double-buffered column store between the FFT magnitude stream and the HDMI graph renderer in the sound2fft display path. Accepts one frame of NUM_COLS magnitude bins over a valid/ready stream, scales each bin to a bar height, and swaps the completed frame into the display bank on the video frame-start pulse so a frame never tears. The renderer presents a column/row coordinate each pixel clock and receives a registered bar/peak pixel decision two cycles later.

---
 rtl/graph_column_buffer.sv | 148 ++++++++++++++
 tb/tb_graph_column_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/graph_column_buffer.sv
// Double-buffered bar-graph column store: scales FFT bins to bar heights and swaps banks on frame_start.
// Optional peak-hold markers are enabled by defining PEAK_HOLD_EN.
module graph_column_buffer #(
  parameter int NUM_COLS   = 64,
  parameter int DATA_W     = 16,
  parameter int SHIFT      = 6,
  parameter int GRAPH_H    = 400,
  parameter int PEAK_DECAY = 4
) (
  input  logic              clk_25m,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              wr_first,
  output logic              wr_ready,
  input  logic              frame_start,
  input  logic [6:0]        rd_col,
  input  logic [8:0]        rd_row,
  output logic              bar_on,
  output logic              peak_on,
  output logic              frame_swapped
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int DEPTH = 1 << COL_W;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t           state;
  logic             wr_bank;
  logic             disp_valid;
  logic [COL_W-1:0] wr_idx;

  logic             do_write;
  logic [COL_W-1:0] wr_addr;
  logic             wr_last;
  logic [31:0]      scaled;
  logic [8:0]       h_new;
  logic [COL_W:0]   rd_addr;

  logic [8:0]       bar_mem [0:2*DEPTH-1];
  logic [8:0]       s1_h;
  logic [8:0]       s1_row;
  logic             s1_valid;

  assign scaled   = 32'(wr_data) >> SHIFT;
  assign h_new    = (scaled > 32'(GRAPH_H)) ? 9'(GRAPH_H) : scaled[8:0];
  // Bins arriving in IDLE without wr_first are consumed but never stored.
  assign do_write = ~rst & wr_valid & wr_ready & (wr_first | (state == FILL));
  assign wr_addr  = wr_first ? '0 : wr_idx;
  assign wr_last  = (wr_addr == COL_W'(NUM_COLS - 1));
  assign rd_addr  = {~wr_bank, rd_col[COL_W-1:0]};

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state         <= IDLE;
      wr_bank       <= 1'b0;
      disp_valid    <= 1'b0;
      wr_idx        <= '0;
      wr_ready      <= 1'b0;
      frame_swapped <= 1'b0;
    end else begin
      frame_swapped <= 1'b0;
      case (state)
        IDLE, FILL: begin
          wr_ready <= 1'b1;
          if (do_write) begin
            if (wr_last) begin
              state    <= DONE;
              wr_idx   <= '0;
              wr_ready <= 1'b0;
            end else begin
              state  <= FILL;
              wr_idx <= wr_addr + 1'b1;
            end
          end
        end
        DONE: begin
          wr_ready <= 1'b0;
          if (frame_start) begin
            wr_bank       <= ~wr_bank;
            disp_valid    <= 1'b1;
            frame_swapped <= 1'b1;
            wr_ready      <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_25m) begin
    if (do_write) bar_mem[{wr_bank, wr_addr}] <= h_new;
    s1_h <= bar_mem[rd_addr];
  end

  // Stage 1 qualifies the coordinate alongside the RAM read; stage 2 makes the pixel decision.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_row   <= '0;
      bar_on   <= 1'b0;
    end else begin
      s1_valid <= disp_valid & ({1'b0, rd_col} < 8'(NUM_COLS)) & (rd_row < 9'(GRAPH_H));
      s1_row   <= rd_row;
      bar_on   <= s1_valid & (({1'b0, s1_row} + {1'b0, s1_h}) >= 10'(GRAPH_H));
    end
  end

`ifdef PEAK_HOLD_EN
  logic [8:0] peak_reg [0:DEPTH-1];
  logic [8:0] peak_mem [0:2*DEPTH-1];
  logic [8:0] p_old;
  logic [8:0] p_dec;
  logic [8:0] p_new;
  logic [8:0] s1_p;

  assign p_old = peak_reg[wr_addr];
  assign p_dec = (p_old > 9'(PEAK_DECAY)) ? p_old - 9'(PEAK_DECAY) : '0;
  assign p_new = (h_new > p_dec) ? h_new : p_dec;

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) peak_reg[i] <= '0;
    end else if (do_write) begin
      peak_reg[wr_addr] <= p_new;
    end
  end

  always_ff @(posedge clk_25m) begin
    if (do_write) peak_mem[{wr_bank, wr_addr}] <= p_new;
    s1_p <= peak_mem[rd_addr];
  end

  always_ff @(posedge clk_25m) begin
    if (rst) peak_on <= 1'b0;
    else     peak_on <= s1_valid & (s1_p != '0) &
                        (({1'b0, s1_row} + {1'b0, s1_p}) == 10'(GRAPH_H));
  end
`else
  assign peak_on = 1'b0;
`endif

endmodule

// File: tb/tb_graph_column_buffer.sv
// Self-checking bench for graph_column_buffer: random frames checked against a frame-level reference model.
// Peak expectations follow PEAK_HOLD_EN when the macro is defined for the build.
module tb_graph_column_buffer;

  localparam int NCOL  = 64;
  localparam int GH    = 400;
  localparam int SH    = 6;
  localparam int DECAY = 4;

  logic        clk_25m = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_first = 1'b0;
  logic        frame_start = 1'b0;
  logic [6:0]  rd_col = '0;
  logic [8:0]  rd_row = '0;
  logic        wr_ready;
  logic        bar_on;
  logic        peak_on;
  logic        frame_swapped;

  int errors = 0;
  int checks = 0;

  // Reference model: the frame being collected, the frame on screen and the running peaks.
  int fill_h[NCOL];
  int fill_p[NCOL];
  int disp_h[NCOL];
  int disp_p[NCOL];
  int peak_hist[NCOL];
  int frame_vals[NCOL];
  bit disp_valid_m;
  bit filling;
  bit frame_full;
  int bins_got;

  always #20 clk_25m = ~clk_25m;

  graph_column_buffer dut (
    .clk_25m       (clk_25m),
    .rst           (rst),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_first      (wr_first),
    .wr_ready      (wr_ready),
    .frame_start   (frame_start),
    .rd_col        (rd_col),
    .rd_row        (rd_row),
    .bar_on        (bar_on),
    .peak_on       (peak_on),
    .frame_swapped (frame_swapped)
  );

  task automatic tick();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bar_height(input int d);
    int s;
    s = d >> SH;
    return (s > GH) ? GH : s;
  endfunction

  task automatic model_reset();
    disp_valid_m = 1'b0;
    filling      = 1'b0;
    frame_full   = 1'b0;
    bins_got     = 0;
    foreach (peak_hist[i]) peak_hist[i] = 0;
  endtask

  task automatic model_accept(input int d, input bit first);
    int h;
    int idx;
    h = bar_height(d);
    if (!filling && !first) return;
    idx = first ? 0 : bins_got;
    fill_h[idx] = h;
`ifdef PEAK_HOLD_EN
    begin
      int dec;
      dec = (peak_hist[idx] > DECAY) ? peak_hist[idx] - DECAY : 0;
      peak_hist[idx] = (h > dec) ? h : dec;
      fill_p[idx] = peak_hist[idx];
    end
`endif
    bins_got = idx + 1;
    filling  = 1'b1;
    if (bins_got == NCOL) begin
      frame_full = 1'b1;
      filling    = 1'b0;
      bins_got   = 0;
    end
  endtask

  task automatic doReset(input int cycles);
    rst         = 1'b1;
    wr_valid    = 1'b0;
    frame_start = 1'b0;
    repeat (cycles) tick();
    model_reset();
    checkOutput("wr_ready_in_reset", wr_ready, 0);
    checkOutput("bar_on_in_reset", bar_on, 0);
    checkOutput("peak_on_in_reset", peak_on, 0);
    checkOutput("frame_swapped_in_reset", frame_swapped, 0);
    rst = 1'b0;
    tick();
    checkOutput("wr_ready_after_reset", wr_ready, 1);
  endtask

  // Offers one bin and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [15:0] d, input bit first, input bit fs);
    int waited;
    waited   = 0;
    wr_data  = d;
    wr_first = first;
    wr_valid = 1'b1;
    while (wr_ready !== 1'b1 && waited < 300) begin
      tick();
      waited++;
    end
    if (wr_ready !== 1'b1) begin
      checkOutput("wr_ready_timeout", wr_ready, 1);
      wr_valid = 1'b0;
      return;
    end
    frame_start = fs;
    tick();
    frame_start = 1'b0;
    wr_valid    = 1'b0;
    wr_first    = 1'b0;
    model_accept(int'(d), first);
  endtask

  task automatic send_frame(input bit fs_on_last);
    for (int k = 0; k < NCOL; k++)
      applyStimulus(16'(frame_vals[k]), k == 0, fs_on_last && (k == NCOL - 1));
    checkOutput("wr_ready_after_frame", wr_ready, frame_full ? 0 : 1);
  endtask

  task automatic random_frame();
    for (int k = 0; k < NCOL; k++)
      frame_vals[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                                  : int'($urandom_range(0, 26000));
  endtask

  task automatic pulseFrameStart();
    bit exp_sw;
    exp_sw      = frame_full;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (exp_sw) begin
      disp_h       = fill_h;
      disp_p       = fill_p;
      disp_valid_m = 1'b1;
      frame_full   = 1'b0;
    end
    checkOutput("frame_swapped_pulse", frame_swapped, exp_sw);
    tick();
    checkOutput("frame_swapped_clear", frame_swapped, 0);
  endtask

  task automatic checkPixel(input int col, input int row);
    bit eb;
    bit ep;
    rd_col = 7'(col);
    rd_row = 9'(row);
    tick();
    tick();
    eb = 1'b0;
    ep = 1'b0;
    if (disp_valid_m && col < NCOL && row < GH) begin
      eb = (row >= GH - disp_h[col]);
      ep = (disp_p[col] > 0) && (row == GH - disp_p[col]);
    end
    checkOutput($sformatf("bar_on c%0d r%0d", col, row), bar_on, eb);
    checkOutput($sformatf("peak_on c%0d r%0d", col, row), peak_on, ep);
  endtask

  task automatic random_probes(input int n);
    int col;
    int row;
    for (int i = 0; i < n; i++) begin
      col = int'($urandom_range(0, NCOL - 1));
      if ($urandom_range(0, 1) == 0) row = GH - disp_h[col] + int'($urandom_range(0, 2)) - 1;
      else                           row = GH - disp_p[col] + int'($urandom_range(0, 2)) - 1;
      if (row < 0) row = 0;
      if (row > 511) row = 511;
      checkPixel(col, row);
    end
  endtask

  initial begin
    int h0;
    model_reset();
    doReset(3);

    // Nothing is displayed before the first swap, and frame_start alone does not swap.
    checkPixel(5, 399);
    checkPixel(0, 0);
    pulseFrameStart();

    // Ramp frame.
    for (int k = 0; k < NCOL; k++) frame_vals[k] = k * 640;
    send_frame(1'b0);
    pulseFrameStart();
    checkPixel(5, 350);
    checkPixel(5, 349);
    checkPixel(0, 399);
    checkPixel(63, 0);
    checkPixel(63, 399);
    checkPixel(63, 400);
    checkPixel(64, 399);
    checkPixel(127, 0);

    // Back-pressure: a completed frame holds off further bins until frame_start.
    random_frame();
    send_frame(1'b0);
    wr_data  = 16'h1234;
    wr_first = 1'b1;
    wr_valid = 1'b1;
    repeat (5) begin
      tick();
      checkOutput("wr_ready_backpressure", wr_ready, 0);
    end
    wr_valid = 1'b0;
    wr_first = 1'b0;
    checkPixel(5, 350);
    checkPixel(5, 349);
    pulseFrameStart();
    random_probes(20);

    // frame_start coincident with the final accept must not swap.
    random_frame();
    send_frame(1'b1);
    checkOutput("no_swap_coincident", frame_swapped, 0);
    checkPixel(10, GH - disp_h[10]);
    pulseFrameStart();
    random_probes(10);

    // Discard in IDLE, then resync after 10 bins.
    for (int k = 0; k < 3; k++) applyStimulus(16'($urandom_range(0, 65535)), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(16'($urandom_range(0, 65535)), k == 0, 1'b0);
    h0 = int'($urandom_range(1, 399));
    applyStimulus(16'(h0 << SH), 1'b1, 1'b0);
    for (int k = 1; k < NCOL - 1; k++) applyStimulus(16'($urandom_range(0, 65535)), 1'b0, 1'b0);
    checkOutput("wr_ready_before_last", wr_ready, 1);
    applyStimulus(16'($urandom_range(0, 65535)), 1'b0, 1'b0);
    checkOutput("wr_ready_resync_done", wr_ready, 0);
    pulseFrameStart();
    checkPixel(0, GH - h0);
    checkPixel(0, GH - h0 - 1);
    random_probes(10);

    // Saturation and range gating.
    random_frame();
    frame_vals[7] = 16'hFFFF;
    send_frame(1'b0);
    pulseFrameStart();
    checkPixel(7, 0);
    checkPixel(7, 399);
    checkPixel(7, 400);
    checkPixel(64, 399);

    // Reset in the middle of a frame drops everything.
    for (int k = 0; k < 20; k++) applyStimulus(16'($urandom_range(0, 65535)), k == 0, 1'b0);
    doReset(1);
    checkPixel(5, 350);
    checkPixel(7, 399);

    // Peak marker: h=100 then h=0 in column 0.
    random_frame();
    frame_vals[0] = 100 << SH;
    send_frame(1'b0);
    pulseFrameStart();
    checkPixel(0, 300);
    checkPixel(0, 299);
    checkPixel(0, 301);
    random_frame();
    frame_vals[0] = 0;
    send_frame(1'b0);
    pulseFrameStart();
    checkPixel(0, 304);
    checkPixel(0, 300);
    checkPixel(0, 303);
    random_probes(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
